// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions used by the fetch stage and the core behind it.
package riscv_pkg;

    localparam int XLEN = 32;

    // Address of the first instruction fetched after reset.
    localparam logic [XLEN-1:0] ResetPc = 32'h8000_0000;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with push, pop, flush and occupancy.
// The head entry is read straight from its register, so a pushed entry becomes
// visible one cycle after the push (no fall-through).
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          push_i,
    input  fetch_entry_t  data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output fetch_entry_t  data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    fetch_entry_t  mem_q [DEPTH];
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy bookkeeping; flush wins over everything else.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage: one register per slot, cleared on reset so the head reads zero.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                mem_q[gi] <= '0;
            end else if (do_push && !flush_i && (wr_ptr_q == AW'(gi))) begin
                mem_q[gi] <= data_i;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word requests under a
// credit limit, tags responses with their PC, buffers them in a prefetch FIFO
// and drops responses that were in flight when a redirect arrived.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = ResetPc
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [31:0]     instr_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   fifo_count_q;
    logic [CW-1:0]   tag_count;
    logic [CW:0]     credit_used;
    logic            grant, resp_keep, fifo_pop;
    logic            fifo_full, fifo_empty, tag_full, tag_empty;
    fetch_entry_t    tag_in, tag_head, fifo_in, fifo_head;
    logic            unused_sink;

    // Every buffered word and every word in flight holds a FIFO slot; a pop in
    // the current cycle does not free a slot until the next one.
    assign credit_used = {1'b0, fifo_count_q} + {1'b0, outstanding_q};
    assign imem_req_o  = rstn_i && !redirect_i && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign imem_addr_o = fetch_pc_q;
    assign grant       = imem_req_o && imem_gnt_i;

    // Only responses issued after the last redirect reach the FIFO.
    assign resp_keep = imem_rvalid_i && (discard_q == '0) && !redirect_i;
    assign fifo_pop  = valid_o && ready_i && !redirect_i;

    assign tag_in  = '{pc: fetch_pc_q, instr: '0};
    assign fifo_in = '{pc: tag_head.pc, instr: imem_rdata_i};

    // PC tags of granted requests, consumed in grant order by responses.
    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_tag_queue (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (grant),
        .data_i  (tag_in),
        .pop_i   (imem_rvalid_i),
        .flush_i (1'b0),
        .data_o  (tag_head),
        .count_o (tag_count),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

    // Prefetch buffer feeding decode.
    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_prefetch (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (resp_keep),
        .data_i  (fifo_in),
        .pop_i   (fifo_pop),
        .flush_i (redirect_i),
        .data_o  (fifo_head),
        .count_o (fifo_count_q),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign valid_o = (fifo_count_q != '0);
    assign pc_o    = fifo_head.pc;
    assign instr_o = fifo_head.instr;

    // Next fetch PC, in-flight count and pending discard count.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid_i);
        discard_d     = discard_q;
        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
            discard_d  = outstanding_q - CW'(imem_rvalid_i);
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (imem_rvalid_i && (discard_q != '0)) discard_d = discard_q - CW'(1);
        end
    end

    // Fetch PC and counter registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // Tag-queue status and unused payload bits only feed the checks below.
    assign unused_sink = &{1'b0, tag_head.instr, fifo_full, fifo_empty,
                           tag_full, tag_empty, tag_count};

`ifndef SYNTHESIS
    a_rvalid_needs_request: assert property (@(posedge clk_i) disable iff (!rstn_i)
        imem_rvalid_i |-> (outstanding_q != '0) && !tag_empty);
    a_tag_no_overflow: assert property (@(posedge clk_i) disable iff (!rstn_i)
        grant |-> !tag_full);
    a_tag_tracks_outstanding: assert property (@(posedge clk_i) disable iff (!rstn_i)
        tag_count == outstanding_q);
    a_discard_bounded: assert property (@(posedge clk_i) disable iff (!rstn_i)
        discard_q <= outstanding_q);
`endif

endmodule
